// File: rtl/operand_stage.sv
// Two-entry operand FIFO between the operand source and the downstream mux bank.
// Each entry carries {a, b, sel}; every output comes straight from a flop.
module operand_stage #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic             out_sel,
  output logic [1:0]       count
);

  localparam int EW = 2 * WIDTH + 1;

  typedef logic [EW-1:0] entry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t     state_q, state_d;
  entry_t     mem_q [2];
  entry_t     mem_d [2];
  entry_t     head_q, head_d;
  logic       wr_ptr_q, wr_ptr_d;
  logic       rd_ptr_q, rd_ptr_d;
  logic       in_ready_q, in_ready_d;
  logic       out_valid_q, out_valid_d;
  logic [1:0] count_q, count_d;
  logic       push_s;
  logic       pop_s;

  assign push_s = in_valid & in_ready_q;
  assign pop_s  = out_valid_q & out_ready;

  // Next-state, storage and registered-output computation.
  always_comb begin
    state_d  = state_q;
    mem_d    = mem_q;
    head_d   = head_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;

    if (push_s) begin
      mem_d[wr_ptr_q] = {in_a, in_b, in_sel};
      wr_ptr_d        = ~wr_ptr_q;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end

    if (pop_s) begin
      rd_ptr_d = ~rd_ptr_q;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end

    case (state_q)
      EMPTY: state_d = push_s ? ONE : EMPTY;
      ONE: begin
        case ({push_s, pop_s})
          2'b10:   state_d = FULL;
          2'b01:   state_d = EMPTY;
          default: state_d = ONE;
        endcase
      end
      FULL:    state_d = pop_s ? ONE : FULL;
      default: state_d = EMPTY;
    endcase

    case (state_d)
      EMPTY:   count_d = 2'd0;
      ONE:     count_d = 2'd1;
      FULL:    count_d = 2'd2;
      default: count_d = 2'd0;
    endcase

    in_ready_d  = (state_d != FULL);
    out_valid_d = (state_d != EMPTY);

    // Head register tracks the entry the read pointer will point at; it holds when empty.
    if (state_d != EMPTY) begin
      head_d = mem_d[rd_ptr_d];
    end else begin
      head_d = head_q;
    end
  end

  // State, storage and output registers with asynchronous clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= EMPTY;
      mem_q[0]    <= {EW{1'b0}};
      mem_q[1]    <= {EW{1'b0}};
      head_q      <= {EW{1'b0}};
      wr_ptr_q    <= 1'b0;
      rd_ptr_q    <= 1'b0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      count_q     <= 2'd0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      head_q      <= head_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      count_q     <= count_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_a     = head_q[EW-1 -: WIDTH];
  assign out_b     = head_q[WIDTH:1];
  assign out_sel   = head_q[0];
  assign count     = count_q;

endmodule

// File: tb/tb_operand_stage.sv
// Scoreboard bench for operand_stage: a queue model of the FIFO contents
// predicts acceptance, occupancy and the head entry every cycle.
module tb_operand_stage;

  localparam int WIDTH = 4;
  typedef logic [2*WIDTH:0] entry_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_a = 4'h0;
  logic [WIDTH-1:0] in_b = 4'h0;
  logic             in_sel = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] out_a;
  logic [WIDTH-1:0] out_b;
  logic             out_sel;
  logic [1:0]       count;

  entry_t sb[$];
  logic   model_rdy = 1'b0;
  int     n_vec = 0;
  int     n_err = 0;

  operand_stage #(.WIDTH(WIDTH)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_sel(in_sel),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_b(out_b), .out_sel(out_sel),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Stimulus side: an accepted offer becomes an expected entry.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      sb.delete();
      model_rdy = 1'b0;
    end else begin
      if (in_valid && model_rdy) sb.push_back({in_a, in_b, in_sel});
      model_rdy = (sb.size() < 2);
    end
  end

  // Monitor: compare the presented head and occupancy, retire the head when consumed.
  always @(negedge clk) begin
    if (!rst) begin
      chk("count", 32'(count), 32'(sb.size()));
      chk("in_ready", 32'(in_ready), 32'(model_rdy));
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (sb.size() != 0) begin
        chk("head", 32'({out_a, out_b, out_sel}), 32'(sb[0]));
        if (out_ready) void'(sb.pop_front());
      end
    end
  end

  task automatic apply(input logic v, input logic [3:0] a, input logic [3:0] b,
                       input logic s, input logic r);
    in_valid  = v;
    in_a      = a;
    in_b      = b;
    in_sel    = s;
    out_ready = r;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_data", 32'({out_a, out_b, out_sel}), 32'd0);
  endtask

  initial begin
    #2;
    chk_reset_state();
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single pass
    apply(1'b1, 4'h3, 4'hC, 1'b1, 1'b1);
    apply(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    apply(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);

    // Fill under backpressure, third offer refused, then drain
    apply(1'b1, 4'h5, 4'hA, 1'b0, 1'b0);
    apply(1'b1, 4'h6, 4'h9, 1'b1, 1'b0);
    apply(1'b1, 4'h7, 4'h7, 1'b1, 1'b0);
    apply(1'b1, 4'h7, 4'h7, 1'b1, 1'b0);
    apply(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    apply(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    apply(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);

    // Streaming through pointer wrap
    for (int i = 0; i < 16; i++) begin
      logic [3:0] v4;
      v4 = 4'(i);
      apply(1'b1, v4, ~v4, v4[0], 1'b1);
    end
    apply(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    apply(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);

    // Reset while full
    apply(1'b1, 4'h1, 4'h2, 1'b0, 1'b0);
    apply(1'b1, 4'h3, 4'h4, 1'b1, 1'b0);
    in_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_reset_state();
    #10;
    rst = 1'b0;
    @(posedge clk);
    #1;
    apply(1'b1, 4'hF, 4'h0, 1'b1, 1'b0);
    apply(1'b0, 4'h0, 4'h0, 1'b0, 1'b0);
    apply(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    apply(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);

    // Random handshakes
    for (int i = 0; i < 10000; i++) begin
      logic [3:0] ra;
      logic [3:0] rb;
      ra = 4'($urandom_range(0, 15));
      rb = 4'($urandom_range(0, 15));
      apply(1'($urandom_range(0, 1)), ra, rb, 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)));
    end
    apply(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    apply(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);
    apply(1'b0, 4'h0, 4'h0, 1'b0, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/operand_stage.md
OPERAND_STAGE -- requirements
Module: operand_stage

Interface
REQ-001 Parameter: WIDTH, 4, operand width in bits; legal range 1..16.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  upstream offers an operand set this cycle.
REQ-005 Port: in_ready  output  1  stage can accept an operand set this cycle.
REQ-006 Port: in_a  input  WIDTH  operand A (mux data input a).
REQ-007 Port: in_b  input  WIDTH  operand B (mux data input b).
REQ-008 Port: in_sel  input  1  mux select; 1 selects A, 0 selects B.
REQ-009 Port: out_valid  output  1  head entry presented to the downstream mux bank.
REQ-010 Port: out_ready  input  1  downstream consumes the head entry this cycle.
REQ-011 Port: out_a, out_b  output  WIDTH each  head-entry operands.
REQ-012 Port: out_sel  output  1  head-entry select.
REQ-013 Port: count  output  2  number of buffered entries, 0..2.

Function
REQ-014 Storage: 2-entry FIFO of {a, b, sel}; all outputs are driven directly from registers, with no combinational path from in_* to out_*.
REQ-015 Push: occurs when in_valid && in_ready at a rising edge.
REQ-016 Pop: occurs when out_valid && out_ready at a rising edge.
REQ-017 States: EMPTY (count=0), ONE (count=1), FULL (count=2); state is a registered encoding.
REQ-018 EMPTY: in_ready=1, out_valid=0; a push moves the state to ONE; out_ready is ignored.
REQ-019 ONE: in_ready=1, out_valid=1.
  - push only -> FULL
  - pop only -> EMPTY
  - push+pop together -> stays ONE, new entry becomes head
REQ-020 FULL: in_ready=0, out_valid=1; in_valid is ignored; a pop -> ONE, with the second entry becoming head.
REQ-021 Latency: an entry pushed into EMPTY appears on out_* with out_valid=1 on the cycle after the push edge; minimum latency is 1 cycle.
REQ-022 in_ready depends only on registered state, never on out_ready, so a simultaneous push+pop in FULL is impossible.
REQ-023 Ordering: strict FIFO; each entry is delivered exactly once with a, b and sel unchanged as a unit.
REQ-024 Stability: while out_valid=1 and out_ready=0, out_a, out_b and out_sel hold constant.
REQ-025 Don't-care data: out_a, out_b and out_sel are don't-care while out_valid=0, but they must not be X after reset.
REQ-026 Pointers: read/write pointers are 1 bit wide and wrap from 1 to 0 with no bubble; count always equals the number of entries held.

Reset
REQ-027 While rst=1, asynchronously and regardless of clk:
  - state=EMPTY, count=0, out_valid=0, in_ready=0
  - out_a=0, out_b=0, out_sel=0, pointers=0
REQ-028 On the first rising clk edge after rst falls, in_ready=1; no push is accepted on that edge.
REQ-029 Reset asserted mid-operation discards all buffered entries; no partial entry survives.

Verification
REQ-030 Single pass: reset; push {a=3, b=C, sel=1}; out_ready=1 -> next cycle out_valid=1, out_a=3, out_b=C, out_sel=1, count=1; the following cycle count=0.
REQ-031 Fill/backpressure: out_ready=0; push 5/A/0 then 6/9/1 -> count=2, in_ready=0, head stays 5/A/0; a third offer 7/7/1 is not accepted.
REQ-032 Drain order: from the REQ-031 state, out_ready=1 for 2 cycles -> 5/A/0 then 6/9/1 delivered, then out_valid=0, count=0, in_ready=1.
REQ-033 Streaming: in_valid=1 and out_ready=1 continuously with operands 0..15 -> one entry out per cycle, count holds at 1, no bubbles after the first, pointers wrap correctly.
REQ-034 Mid-operation reset: with count=2, assert rst between clock edges -> out_valid=0 and count=0 immediately; after release, a push of F/0/1 is delivered as the first entry.
REQ-035 Random: randomized in_valid and out_ready for 10k cycles against a scoreboard -> no loss, no duplication, no reordering, and out_* stable during stalls.
